// File: rtl/uart_tx_frame_arbiter.sv
// uart_tx_frame_arbiter
// Shares one UART byte transmitter between NUM_REQ clients. Arbitration is
// round-robin and frame-atomic: a winner keeps the transmitter until its
// SYNC, ID, LEN and payload bytes have all been sent.
// Optional feature macro: UART_ARB_CSUM_EN. When defined, a checksum byte
// (two's complement of the mod-256 sum of ID, LEN and payload) closes
// every frame.
module uart_tx_frame_arbiter #(
  parameter int         NUM_REQ   = 4,
  parameter logic [7:0] SYNC_BYTE = 8'hA5,
  parameter logic [7:0] ID_BASE   = 8'h10
) (
  input  logic                 i_Clock,
  input  logic                 i_Rst_n,
  input  logic [NUM_REQ-1:0]   i_Req,
  input  logic [8*NUM_REQ-1:0] i_Len,
  input  logic [8*NUM_REQ-1:0] i_Data,
  output logic [NUM_REQ-1:0]   o_Data_Ack,
  output logic [NUM_REQ-1:0]   o_Grant,
  output logic                 o_Busy,
  output logic                 o_Tx_DV,
  output logic [7:0]           o_Tx_Byte,
  input  logic                 i_Tx_Active,
  input  logic                 i_Tx_Done
);

  localparam int IDX_W = $clog2(NUM_REQ);

  typedef enum logic [2:0] {
    ST_IDLE, ST_ARB, ST_SYNC, ST_ID, ST_LEN, ST_PAYLOAD, ST_CSUM, ST_WAIT
  } state_t;

`ifdef UART_ARB_CSUM_EN
  localparam state_t AFTER_DATA = ST_CSUM;
`else
  localparam state_t AFTER_DATA = ST_IDLE;
`endif

  state_t             state, next_state, last_sent;
  logic [IDX_W-1:0]   rr_ptr, grant_idx, arb_idx, next_ptr;
  logic               arb_found;
  logic [7:0]         len_q, remaining, tx_byte_q, cur_byte, id_byte, payload_byte;
  logic [NUM_REQ-1:0] grant_q;
  logic               busy_q, done_q, done_rise;
`ifdef UART_ARB_CSUM_EN
  logic [7:0]         csum_q;
`endif

  // Done may be held for several cycles; only its rising edge advances a frame.
  assign done_rise    = i_Tx_Done & ~done_q;
  assign id_byte      = ID_BASE + 8'(grant_idx);
  assign payload_byte = i_Data[{grant_idx, 3'b000} +: 8];
  assign o_Grant      = grant_q;
  assign o_Busy       = busy_q;
  assign o_Tx_Byte    = cur_byte;

  // Round-robin search: first requester at or after the pointer, wrapping.
  always_comb begin
    arb_found = 1'b0;
    arb_idx   = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!arb_found && i_Req[(int'(rr_ptr) + i) % NUM_REQ]) begin
        arb_found = 1'b1;
        arb_idx   = IDX_W'((int'(rr_ptr) + i) % NUM_REQ);
      end
    end
    next_ptr = (arb_idx == IDX_W'(NUM_REQ - 1)) ? '0 : arb_idx + IDX_W'(1);
  end

  // State register.
  always_ff @(posedge i_Clock or negedge i_Rst_n) begin
    if (!i_Rst_n) state <= ST_IDLE;
    else          state <= next_state;
  end

  // Next-state logic; each send state lasts one cycle, then waits for done.
  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE:    if (|i_Req && !i_Tx_Active) next_state = ST_ARB;
      ST_ARB:     next_state = arb_found ? ST_SYNC : ST_IDLE;
      ST_SYNC, ST_ID, ST_LEN, ST_PAYLOAD, ST_CSUM: next_state = ST_WAIT;
      ST_WAIT: begin
        if (done_rise) begin
          case (last_sent)
            ST_SYNC:    next_state = ST_ID;
            ST_ID:      next_state = ST_LEN;
            ST_LEN:     next_state = (len_q != 8'd0) ? ST_PAYLOAD : AFTER_DATA;
            ST_PAYLOAD: next_state = (remaining != 8'd0) ? ST_PAYLOAD : AFTER_DATA;
            default:    next_state = ST_IDLE;
          endcase
        end
      end
      default:    next_state = ST_IDLE;
    endcase
  end

  // Output decode: strobe, byte to send and payload acknowledge per state.
  always_comb begin
    o_Tx_DV    = 1'b0;
    o_Data_Ack = '0;
    cur_byte   = tx_byte_q;
    case (state)
      ST_SYNC: begin
        o_Tx_DV  = 1'b1;
        cur_byte = SYNC_BYTE;
      end
      ST_ID: begin
        o_Tx_DV  = 1'b1;
        cur_byte = id_byte;
      end
      ST_LEN: begin
        o_Tx_DV  = 1'b1;
        cur_byte = len_q;
      end
      ST_PAYLOAD: begin
        o_Tx_DV    = 1'b1;
        cur_byte   = payload_byte;
        o_Data_Ack = NUM_REQ'(1) << grant_idx;
      end
`ifdef UART_ARB_CSUM_EN
      ST_CSUM: begin
        o_Tx_DV  = 1'b1;
        cur_byte = ~csum_q + 8'd1;
      end
`endif
      default: ;
    endcase
  end

  // Frame datapath: winner latch, byte hold, remaining count and checksum.
  always_ff @(posedge i_Clock or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      done_q    <= 1'b0;
      rr_ptr    <= '0;
      grant_idx <= '0;
      grant_q   <= '0;
      busy_q    <= 1'b0;
      len_q     <= 8'd0;
      remaining <= 8'd0;
      tx_byte_q <= 8'd0;
      last_sent <= ST_IDLE;
`ifdef UART_ARB_CSUM_EN
      csum_q    <= 8'd0;
`endif
    end else begin
      done_q <= i_Tx_Done;
      case (state)
        ST_ARB: begin
          if (arb_found) begin
            grant_idx <= arb_idx;
            len_q     <= i_Len[{arb_idx, 3'b000} +: 8];
            remaining <= i_Len[{arb_idx, 3'b000} +: 8];
            grant_q   <= NUM_REQ'(1) << arb_idx;
            busy_q    <= 1'b1;
            rr_ptr    <= next_ptr;
`ifdef UART_ARB_CSUM_EN
            csum_q    <= 8'd0;
`endif
          end
        end
        ST_SYNC: begin
          last_sent <= state;
          tx_byte_q <= cur_byte;
        end
        ST_ID, ST_LEN: begin
          last_sent <= state;
          tx_byte_q <= cur_byte;
`ifdef UART_ARB_CSUM_EN
          csum_q    <= csum_q + cur_byte;
`endif
        end
        ST_PAYLOAD: begin
          last_sent <= state;
          tx_byte_q <= cur_byte;
          remaining <= remaining - 8'd1;
`ifdef UART_ARB_CSUM_EN
          csum_q    <= csum_q + cur_byte;
`endif
        end
`ifdef UART_ARB_CSUM_EN
        ST_CSUM: begin
          last_sent <= state;
          tx_byte_q <= cur_byte;
        end
`endif
        ST_WAIT: begin
          if (next_state == ST_IDLE) begin
            grant_q <= '0;
            busy_q  <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
